// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU operand loader and its ALU consumers.
package alu_pkg;

  localparam int ALU_A_W  = 4;
  localparam int ALU_B_W  = 2;
  localparam int ALU_OP_W = 3;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a registered
// single-cycle press pulse on each debounced rising transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             press_q, press_d;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    count_d = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (count_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      count_q <= count_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures A, B and the opcode from the switches on successive button presses
// and presents them as registered ALU inputs with a valid flag and start pulse.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int OP_W            = ALU_OP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         sw,
  input  logic               btn,
  output logic [ALU_A_W-1:0] A,
  output logic [ALU_B_W-1:0] B,
  output logic [OP_W-1:0]    op,
  output logic               operands_valid,
  output logic               start,
  output logic [1:0]         stage
);

  logic press;

  loader_state_t      state_q, state_d;
  logic [ALU_A_W-1:0] a_q, a_d;
  logic [ALU_B_W-1:0] b_q, b_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               valid_q, valid_d;
  logic               start_q, start_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn),
    .press  (press)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    start_d = 1'b0;
    if (press) begin
      unique case (state_q)
        LOAD_A: begin
          a_d     = sw[ALU_A_W-1:0];
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = sw[ALU_B_W-1:0];
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          op_d    = sw[OP_W-1:0];
          valid_d = 1'b1;
          start_d = 1'b1;
          state_d = READY;
        end
        READY: begin
          // Reload starts at A; B and op stay until overwritten.
          a_d     = sw[ALU_A_W-1:0];
          valid_d = 1'b0;
          state_d = LOAD_B;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      start_q <= start_d;
    end
  end

  assign A              = a_q;
  assign B              = b_q;
  assign op             = op_q;
  assign operands_valid = valid_q;
  assign start          = start_q;
  assign stage          = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed/randomized bench for alu_operand_loader with a field-level reference model.
module tb_alu_operand_loader;

  localparam int DEB          = 4;
  localparam int OPW          = 3;
  localparam int CAPTURE_EDGE = DEB + 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           btn;
  logic [3:0]     sw;
  logic [3:0]     A;
  logic [1:0]     B;
  logic [OPW-1:0] op;
  logic           operands_valid;
  logic           start;
  logic [1:0]     stage;

  int checks = 0;
  int errors = 0;

  // Reference model: which field the next press loads, and the field contents.
  int             m_stage;
  logic [3:0]     m_a;
  logic [1:0]     m_b;
  logic [OPW-1:0] m_op;
  logic           m_valid;
  logic           m_start;

  int bounce_pat [16] = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  alu_operand_loader #(
    .DEBOUNCE_CYCLES(DEB),
    .OP_W           (OPW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sw            (sw),
    .btn           (btn),
    .A             (A),
    .B             (B),
    .op            (op),
    .operands_valid(operands_valid),
    .start         (start),
    .stage         (stage)
  );

  always #5 clk = ~clk;

  task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".A"},     8'(A),              8'(m_a));
    checkOne({tag, ".B"},     8'(B),              8'(m_b));
    checkOne({tag, ".op"},    8'(op),             8'(m_op));
    checkOne({tag, ".valid"}, 8'(operands_valid), 8'(m_valid));
    checkOne({tag, ".start"}, 8'(start),          8'(m_start));
    checkOne({tag, ".stage"}, 8'(stage),          8'(m_stage));
  endtask

  task automatic modelReset();
    m_stage = 0;
    m_a     = '0;
    m_b     = '0;
    m_op    = '0;
    m_valid = 1'b0;
    m_start = 1'b0;
  endtask

  // A complete set exists only once all three fields have been loaded in order.
  task automatic modelPress(input logic [3:0] v);
    if (m_stage == 0 || m_stage == 3) begin
      m_a     = v;
      m_valid = 1'b0;
      m_stage = 1;
    end else if (m_stage == 1) begin
      m_b     = v[1:0];
      m_stage = 2;
    end else begin
      m_op    = v[OPW-1:0];
      m_valid = 1'b1;
      m_start = 1'b1;
      m_stage = 3;
    end
  endtask

  // Hold btn for 'hold' edges with sw=v, then release; every edge is checked.
  task automatic applyStimulus(input logic [3:0] v, input int hold, input string tag);
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      m_start = 1'b0;
      if (k == CAPTURE_EDGE) modelPress(v);
      checkOutput(tag);
    end
    @(negedge clk);
    btn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      m_start = 1'b0;
      checkOutput({tag, "_rel"});
    end
  endtask

  initial begin
    rst = 1'b0;
    btn = 1'b0;
    sw  = 4'd0;
    modelReset();

    // Asynchronous reset mid-clock with the button idle.
    #23;
    rst = 1'b1;
    #1;
    checkOutput("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Bounce shorter than the debounce window must not capture.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      btn = bounce_pat[i][0];
      @(posedge clk);
      #1;
      checkOutput("bounce");
    end

    applyStimulus(4'b1010, 10, "loadA_long");

    // Switch activity in LOAD_B without a press changes nothing.
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      sw = 4'(v);
      @(posedge clk);
      #1;
      checkOutput("sw_noise");
    end

    applyStimulus(4'b0011, CAPTURE_EDGE, "loadB");
    applyStimulus(4'b0101, CAPTURE_EDGE, "loadOp");

    applyStimulus(4'b0001, CAPTURE_EDGE, "reloadA");
    applyStimulus(4'($urandom_range(0, 15)), CAPTURE_EDGE, "reloadB");
    applyStimulus(4'($urandom_range(0, 15)), CAPTURE_EDGE, "reloadOp");

    applyStimulus(4'($urandom_range(0, 15)), CAPTURE_EDGE, "preA");
    applyStimulus(4'($urandom_range(0, 15)), CAPTURE_EDGE, "preB");

    // Reset while waiting for the opcode clears everything immediately.
    @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), CAPTURE_EDGE + $urandom_range(0, 3), "randLoad");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
